// File: rtl/rns_conv_pkg.sv
// rns_conv_pkg: residue type, default moduli and elaboration-time helpers
// shared by the RNS-to-mixed-radix conversion stages.
package rns_conv_pkg;

    typedef logic [17:0] residue_t;
    typedef logic [511:0][17:0] rom_t;

    localparam int unsigned M1_DEF = 262139;
    localparam int unsigned M2_DEF = 262133;
    localparam int unsigned M3_DEF = 262127;
    localparam int unsigned M4_DEF = 262121;
    localparam int unsigned M5_DEF = 262111;
    localparam int unsigned M6_DEF = 262109;

    // Extended Euclid; evaluated only at elaboration.
    function automatic int unsigned modinv(input int unsigned a, input int unsigned m);
        longint t = 0;
        longint nt = 1;
        longint r = longint'(m);
        longint nr = longint'(a) % longint'(m);
        longint q;
        longint tmp;
        while (nr != 0) begin
            q = r / nr;
            tmp = t - q * nt;
            t = nt;
            nt = tmp;
            tmp = r - q * nr;
            r = nr;
            nr = tmp;
        end
        return 32'(t < 0 ? t + longint'(m) : t);
    endfunction

    // Table of (i * 2^shift * c) mod m for a 9-bit slice i.
    function automatic rom_t rom_init(input int unsigned c, input int unsigned m, input int shift);
        rom_t t;
        for (int i = 0; i < 512; i++)
            t[i] = 18'(((longint'(i) << shift) % longint'(m)) * longint'(c) % longint'(m));
        return t;
    endfunction

    function automatic residue_t creduce(input residue_t x, input logic [18:0] m);
        return ({1'b0, x} >= m) ? residue_t'({1'b0, x} - m) : x;
    endfunction

    function automatic residue_t modsub(input residue_t x, input residue_t y, input logic [18:0] m);
        logic [18:0] d;
        d = {1'b0, x} - {1'b0, y};
        return d[18] ? residue_t'(d + m) : d[17:0];
    endfunction

endpackage

// File: rtl/rfrac_conv18_16_stg1_if.sv
// rfrac_conv18_16_stg1_if: residue bus into and out of the first conversion stage.
interface rfrac_conv18_16_stg1_if;
    import rns_conv_pkg::*;

    residue_t RNS_D1_in;
    residue_t RNS_D2_in;
    residue_t RNS_D3_in;
    residue_t RNS_D4_in;
    residue_t RNS_D5_in;
    residue_t RNS_D6_in;
    residue_t mr_A3_out;
    residue_t mr_A4_out;
    residue_t mr_A5_out;
    residue_t mr_A6_out;

    modport master (
        output RNS_D1_in, RNS_D2_in, RNS_D3_in, RNS_D4_in, RNS_D5_in, RNS_D6_in,
        input  mr_A3_out, mr_A4_out, mr_A5_out, mr_A6_out
    );

    modport slave (
        input  RNS_D1_in, RNS_D2_in, RNS_D3_in, RNS_D4_in, RNS_D5_in, RNS_D6_in,
        output mr_A3_out, mr_A4_out, mr_A5_out, mr_A6_out
    );

endinterface

// File: rtl/rns_const_modmult.sv
// rns_const_modmult: two-cycle (x * CONST) mod MOD using split 9-bit lookup tables.
module rns_const_modmult
    import rns_conv_pkg::*;
#(
    parameter int unsigned MOD   = M1_DEF,
    parameter int unsigned CONST = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  residue_t x_i,
    output residue_t y_o
);

    localparam logic [18:0] M  = 19'(MOD);
    localparam rom_t        LO = rom_init(CONST, MOD, 0);
    localparam rom_t        HI = rom_init(CONST, MOD, 9);

    residue_t    lo_q, hi_q, y_q, y_d;
    logic [18:0] sum;

    // Both partial products are below MOD, so one subtract fully reduces.
    always_comb begin
        sum = {1'b0, lo_q} + {1'b0, hi_q};
        y_d = (sum >= M) ? residue_t'(sum - M) : sum[17:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= '0;
            hi_q <= '0;
            y_q  <= '0;
        end else begin
            lo_q <= LO[x_i[8:0]];
            hi_q <= HI[x_i[17:9]];
            y_q  <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/rfrac_conv18_16_stg1.sv
// rfrac_conv18_16_stg1: removes mixed-radix digits a1 and a2 from six residues,
// yielding the partially converted residues for digits 3..6 after 6 clocks.
module rfrac_conv18_16_stg1
    import rns_conv_pkg::*;
#(
    parameter int unsigned M1 = M1_DEF,
    parameter int unsigned M2 = M2_DEF,
    parameter int unsigned M3 = M3_DEF,
    parameter int unsigned M4 = M4_DEF,
    parameter int unsigned M5 = M5_DEF,
    parameter int unsigned M6 = M6_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rfrac_conv18_16_stg1_if.slave bus
);

    localparam int unsigned MK [4] = '{M3, M4, M5, M6};
    localparam logic [18:0] W1 = 19'(M1);
    localparam logic [18:0] W2 = 19'(M2);

    residue_t a1, a2, d2_d, d2_q;
    residue_t rk [4];
    residue_t ak [4];

    assign rk = '{bus.RNS_D3_in, bus.RNS_D4_in, bus.RNS_D5_in, bus.RNS_D6_in};

    always_comb begin
        a1   = creduce(bus.RNS_D1_in, W1);
        d2_d = modsub(creduce(bus.RNS_D2_in, W2), creduce(a1, W2), W2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d2_q <= '0;
        else        d2_q <= d2_d;
    end

    // a2 becomes valid in step with the first multiply of every digit lane.
    rns_const_modmult #(.MOD(M2), .CONST(modinv(M1, M2))) u_a2 (
        .clk   (clk),
        .rst_n (rst_n),
        .x_i   (d2_q),
        .y_o   (a2)
    );

    for (genvar g = 0; g < 4; g++) begin : g_k
        localparam int unsigned MOD = MK[g];
        localparam logic [18:0] W   = 19'(MOD);

        residue_t d_d, d_q, p, e_d, e_q, q, o_q;

        always_comb begin
            d_d = modsub(creduce(rk[g], W), creduce(a1, W), W);
            e_d = modsub(p, creduce(a2, W), W);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d_q <= '0;
                e_q <= '0;
                o_q <= '0;
            end else begin
                d_q <= d_d;
                e_q <= e_d;
                o_q <= q;
            end
        end

        rns_const_modmult #(.MOD(MOD), .CONST(modinv(M1, MOD))) u_m1 (
            .clk   (clk),
            .rst_n (rst_n),
            .x_i   (d_q),
            .y_o   (p)
        );

        rns_const_modmult #(.MOD(MOD), .CONST(modinv(M2, MOD))) u_m2 (
            .clk   (clk),
            .rst_n (rst_n),
            .x_i   (e_q),
            .y_o   (q)
        );

        assign ak[g] = o_q;
    end

    assign bus.mr_A3_out = ak[0];
    assign bus.mr_A4_out = ak[1];
    assign bus.mr_A5_out = ak[2];
    assign bus.mr_A6_out = ak[3];

endmodule

// File: tb/tb_rfrac_conv18_16_stg1.sv
// tb_rfrac_conv18_16_stg1: random and directed stimulus against a modular-arithmetic
// reference model, plus known-digit checks built from x = c + M1*d + M1*M2*e.
module tb_rfrac_conv18_16_stg1;

    localparam longint M [6] = '{262139, 262133, 262127, 262121, 262111, 262109};

    typedef logic [3:0][17:0] quad_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    rfrac_conv18_16_stg1_if bus ();

    rfrac_conv18_16_stg1 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    longint      inv1 [6];
    longint      inv2 [6];
    quad_t       pipe [7];
    longint      kpipe [7];
    logic [17:0] r [6];
    longint      kcur = -1;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic longint inv(input longint a, input longint m);
        for (longint i = 1; i < m; i++)
            if ((a % m) * i % m == 1) return i;
        return 0;
    endfunction

    function automatic longint msub(input longint x, input longint y, input longint m);
        return ((x % m) - (y % m) + m) % m;
    endfunction

    function automatic quad_t model();
        quad_t  o;
        longint a1, a2, t;
        a1 = r[0] % M[0];
        a2 = msub(r[1], a1, M[1]) * inv1[1] % M[1];
        for (int k = 2; k < 6; k++) begin
            t = msub(r[k], a1, M[k]) * inv1[k] % M[k];
            o[k-2] = 18'(msub(t, a2, M[k]) * inv2[k] % M[k]);
        end
        return o;
    endfunction

    function automatic quad_t outs();
        return {bus.mr_A6_out, bus.mr_A5_out, bus.mr_A4_out, bus.mr_A3_out};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        bus.RNS_D1_in = r[0];
        bus.RNS_D2_in = r[1];
        bus.RNS_D3_in = r[2];
        bus.RNS_D4_in = r[3];
        bus.RNS_D5_in = r[4];
        bus.RNS_D6_in = r[5];
    endtask

    task automatic clear_pipe();
        for (int i = 0; i < 7; i++) begin
            pipe[i]  = '0;
            kpipe[i] = -1;
        end
    endtask

    task automatic step();
        quad_t got;
        drive();
        @(posedge clk);
        for (int i = 6; i > 0; i--) begin
            pipe[i]  = pipe[i-1];
            kpipe[i] = kpipe[i-1];
        end
        pipe[0]  = rst_n ? model() : '0;
        kpipe[0] = rst_n ? kcur : -1;
        #1;
        got = outs();
        for (int j = 0; j < 4; j++) begin
            check($sformatf("model_A%0d", j + 3), 64'(got[j]), 64'(pipe[6][j]));
            if (kpipe[6] >= 0) check($sformatf("known_A%0d", j + 3), 64'(got[j]), 64'(kpipe[6]));
        end
    endtask

    task automatic set_x(input longint c, input longint d, input longint e);
        longint x;
        x = c + M[0] * d + M[0] * M[1] * e;
        for (int k = 0; k < 6; k++) r[k] = 18'(x % M[k]);
        kcur = e;
    endtask

    task automatic set_rand();
        for (int k = 0; k < 6; k++) r[k] = 18'($urandom_range(0, 262143));
        kcur = -1;
    endtask

    task automatic pulse_reset();
        quad_t got;
        rst_n = 1'b0;
        clear_pipe();
        #1;
        got = outs();
        for (int j = 0; j < 4; j++) check($sformatf("async_rst_A%0d", j + 3), 64'(got[j]), 64'd0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        quad_t got;
        for (int k = 1; k < 6; k++) inv1[k] = inv(M[0], M[k]);
        for (int k = 2; k < 6; k++) inv2[k] = inv(M[1], M[k]);
        clear_pipe();
        set_rand();
        drive();
        #1 rst_n = 1'b0;
        #1;
        got = outs();
        for (int j = 0; j < 4; j++) check($sformatf("reset_A%0d", j + 3), 64'(got[j]), 64'd0);
        repeat (4) begin
            set_rand();
            step();
        end
        // Release with zero inputs: outputs must stay zero throughout.
        for (int k = 0; k < 6; k++) r[k] = '0;
        kcur = 0;
        rst_n = 1'b1;
        repeat (8) step();
        for (int k = 0; k < 6; k++) r[k] = 18'd12345;
        repeat (7) step();
        set_x(1000, 2000, 7);
        step();
        kcur = -1;
        for (int k = 0; k < 6; k++) r[k] = '0;
        repeat (6) step();
        // Back-to-back stream with a one-cycle reset pulse in the middle.
        for (int e = 0; e < 100; e++) begin
            set_x($urandom_range(0, 262138), $urandom_range(0, 262132), e);
            step();
            if (e == 50) pulse_reset();
        end
        kcur = -1;
        r[0] = 18'(M[0] - 1);
        r[1] = 18'($urandom_range(0, 262132));
        for (int k = 2; k < 6; k++) r[k] = '0;
        step();
        for (int k = 2; k < 6; k++) r[k] = 18'(M[k] + 5);
        step();
        for (int k = 2; k < 6; k++) r[k] = 18'd5;
        step();
        r[0] = 18'(M[0] + 3);
        r[1] = 18'(M[1] + 7);
        step();
        repeat (200) begin
            set_rand();
            if ($urandom_range(0, 3) == 0) for (int k = 2; k < 6; k++) r[k] = r[0];
            step();
        end
        for (int k = 0; k < 6; k++) r[k] = '0;
        repeat (7) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
